// File: rtl/wptr_handler.sv
// Write-side pointer and flag logic for an asynchronous FIFO.
// Optional sticky overflow flag enabled by defining WPTR_OVERFLOW_FLAG_EN.
module wptr_handler #(
    parameter int PTR_WIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 w_en,
    input  logic                 clr_ovf,
    input  logic [PTR_WIDTH:0]   g_rptr_sync,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic                 wr_accept,
    output logic                 full,
    output logic                 afull,
    output logic [PTR_WIDTH:0]   wlevel,
    output logic                 overflow
);

    localparam int W = PTR_WIDTH + 1;
    localparam logic [W-1:0] AFULL_LVL = W'(AFULL_THRESH);

    logic [W-1:0] bWptr_q, bWptr_d;
    logic [W-1:0] gWptr_q, gWptr_d;
    logic [W-1:0] level_q, level_d;
    logic [W-1:0] bRptrSync;
    logic         full_q, full_d;
    logic         afull_q, afull_d;

    // Gating uses the registered full, so a write is dropped even if the
    // read pointer advances in the same cycle.
    assign wr_accept = w_en & ~full_q;

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    always_comb begin
        bRptrSync = '0;
        for (int i = 0; i < W; i++) begin
            bRptrSync[i] = ^(g_rptr_sync >> i);
        end
    end

    always_comb begin
        bWptr_d = bWptr_q + W'(wr_accept);
        gWptr_d = (bWptr_d >> 1) ^ bWptr_d;
        full_d  = (gWptr_d == {~g_rptr_sync[W-1:W-2], g_rptr_sync[W-3:0]});
        level_d = bWptr_d - bRptrSync;
        afull_d = (level_d >= AFULL_LVL);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            bWptr_q <= '0;
            gWptr_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            bWptr_q <= bWptr_d;
            gWptr_q <= gWptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
        end
    end

    assign b_wptr = bWptr_q;
    assign g_wptr = gWptr_q;
    assign wlevel = level_q;
    assign full   = full_q;
    assign afull  = afull_q;

`ifdef WPTR_OVERFLOW_FLAG_EN
    logic ovf_q, ovf_d;

    // Set wins over clear when both happen in the same cycle.
    always_comb begin
        ovf_d = (w_en & full_q) | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    logic unusedClrOvf;
    assign unusedClrOvf = clr_ovf;
    assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_handler.sv
// Scoreboard testbench for wptr_handler (PTR_WIDTH=3, AFULL_THRESH=6).
// Expected register values are queued at drive time and compared after each edge.
module tb_wptr_handler;

    localparam int PW = 3;
    localparam int W  = PW + 1;

    typedef struct packed {
        logic [W-1:0] b;
        logic [W-1:0] g;
        logic [W-1:0] lvl;
        logic         f;
        logic         af;
        logic         ov;
    } exp_t;

    logic         wclk = 1'b0;
    logic         wrst = 1'b1;
    logic         w_en = 1'b0;
    logic         clr_ovf = 1'b0;
    logic [W-1:0] g_rptr_sync = '0;
    logic [W-1:0] b_wptr, g_wptr, wlevel;
    logic         wr_accept, full, afull, overflow;

    wptr_handler #(.PTR_WIDTH(PW), .AFULL_THRESH(6)) dut (
        .wclk(wclk), .wrst(wrst), .w_en(w_en), .clr_ovf(clr_ovf),
        .g_rptr_sync(g_rptr_sync), .b_wptr(b_wptr), .g_wptr(g_wptr),
        .wr_accept(wr_accept), .full(full), .afull(afull),
        .wlevel(wlevel), .overflow(overflow)
    );

    always #5 wclk = ~wclk;

    int           vectors = 0;
    int           miscompares = 0;
    exp_t         sb[$];
    logic [W-1:0] mB = '0;
    logic         mFull = 1'b0;
    logic         mOvf = 1'b0;
    logic         mValid = 1'b0;
    logic         sawFullInTrack = 1'b0;

    function automatic logic [W-1:0] toGray(input logic [W-1:0] v);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [W-1:0] fromGray(input logic [W-1:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic clr, input logic rst, input logic [W-1:0] grptr);
        exp_t         e;
        exp_t         got;
        logic         acc;
        logic [W-1:0] lvl;
        @(negedge wclk);
        w_en = we; clr_ovf = clr; wrst = rst; g_rptr_sync = grptr;
        #1;
        acc = we & ~mFull;
        if (mValid) checkOutput("wr_accept", {31'd0, wr_accept}, {31'd0, acc});
        if (rst) begin
            mB = '0; mFull = 1'b0; mOvf = 1'b0;
            e = '0;
        end else begin
`ifdef WPTR_OVERFLOW_FLAG_EN
            mOvf = (we & mFull) | (mOvf & ~clr);
`else
            mOvf = 1'b0;
`endif
            mB    = mB + W'(acc);
            lvl   = mB - fromGray(grptr);
            mFull = (lvl == W'(8));
            e.b = mB; e.g = toGray(mB); e.lvl = lvl;
            e.f = mFull; e.af = (lvl >= W'(6)); e.ov = mOvf;
        end
        mValid = 1'b1;
        sb.push_back(e);
        @(posedge wclk);
        #1;
        got = sb.pop_front();
        checkOutput("b_wptr", {28'd0, b_wptr}, {28'd0, got.b});
        checkOutput("g_wptr", {28'd0, g_wptr}, {28'd0, got.g});
        checkOutput("wlevel", {28'd0, wlevel}, {28'd0, got.lvl});
        checkOutput("full", {31'd0, full}, {31'd0, got.f});
        checkOutput("afull", {31'd0, afull}, {31'd0, got.af});
        checkOutput("overflow", {31'd0, overflow}, {31'd0, got.ov});
    endtask

    initial begin
        // Reset with w_en high: second cycle also checks wr_accept during reset
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);

        // Fill to full; afull must first rise after the 6th write
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
            checkOutput("afull_edge", {31'd0, afull}, {31'd0, (i >= 6)});
        end
        checkOutput("g_wptr_at_full", {28'd0, g_wptr}, 32'hC);
        checkOutput("full_at_8", {31'd0, full}, 32'd1);

        // Writes while full are dropped and flag overflow; then clear it
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("b_wptr_hold", {28'd0, b_wptr}, 32'd8);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
        checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Reader advances to binary 3
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010);
        checkOutput("wlevel_after_read", {28'd0, wlevel}, 32'd5);

        // Refill to full, then read pointer advances in the same cycle as a write
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 4'b0010);
        checkOutput("full_again", {31'd0, full}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, toGray(4'd4));
        checkOutput("same_cycle_drop", {28'd0, b_wptr}, 32'd11);
        applyStimulus(1'b1, 1'b0, 1'b0, toGray(4'd4));
        checkOutput("write_after_drop", {28'd0, b_wptr}, 32'd12);

        // Reset mid-burst with w_en held, then resume
        applyStimulus(1'b0, 1'b1, 1'b0, toGray(4'd10));
        applyStimulus(1'b1, 1'b0, 1'b0, toGray(4'd10));
        applyStimulus(1'b1, 1'b0, 1'b1, toGray(4'd10));
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("resume_from_0", {28'd0, b_wptr}, 32'd1);

        // Reader trails so the level stays at 2 across a pointer wrap
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, toGray(mB - 4'd1));
            checkOutput("track_level", {28'd0, wlevel}, 32'd2);
            if (full) sawFullInTrack = 1'b1;
        end
        checkOutput("track_no_full", {31'd0, sawFullInTrack}, 32'd0);
        checkOutput("track_wrapped", {28'd0, b_wptr}, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
